// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
//
// Round-robin arbiter that shares one Wishbone slave (the configuration /
// register bus of the queueing system) between NUM_MASTERS Wishbone masters.
// Ownership is granted for a whole bus cycle: from the owner's cyc rising
// until it drops. While a master owns the bus, its request is muxed to the
// slave and the slave ack is routed back to it. A watchdog terminates slave
// cycles that never ack and returns a one-cycle error pulse to the owner.
//
// Ports
//   clk_i, rst_i    clock, asynchronous active-high reset
//   m_wb_cyc_i      per-master cycle request
//   m_wb_we_i       per-master write enable
//   m_wb_stb_i      per-master byte strobes, master k at slice k
//   m_wb_addr_i     per-master address, master k at slice k
//   m_wb_data_i     per-master write data, master k at slice k
//   m_wb_data_o     slave read data, broadcast to every master
//   m_wb_ack_o      ack, only the owner's bit can be set
//   m_wb_err_o      timeout error pulse, only the owner's bit can be set
//   s_wb_*_o        request towards the slave (owner's slices while owning)
//   s_wb_data_i     slave read data
//   s_wb_ack_i      slave ack
//   grant_o         one-hot registered grant, 0 when idle
//   busy_o          high while the arbiter is not idle
// ---------------------------------------------------------------------------
module wb_rr_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NUM_MASTERS-1:0]                m_wb_cyc_i,
    input  logic [NUM_MASTERS-1:0]                m_wb_we_i,
    input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_wb_stb_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_wb_addr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_wb_data_i,
    output logic [DATA_WIDTH-1:0]                 m_wb_data_o,
    output logic [NUM_MASTERS-1:0]                m_wb_ack_o,
    output logic [NUM_MASTERS-1:0]                m_wb_err_o,
    output logic                                  s_wb_cyc_o,
    output logic                                  s_wb_we_o,
    output logic [DATA_WIDTH/8-1:0]               s_wb_stb_o,
    output logic [ADDR_WIDTH-1:0]                 s_wb_addr_o,
    output logic [DATA_WIDTH-1:0]                 s_wb_data_o,
    input  logic [DATA_WIDTH-1:0]                 s_wb_data_i,
    input  logic                                  s_wb_ack_i,
    output logic [NUM_MASTERS-1:0]                grant_o,
    output logic                                  busy_o
);

    localparam int SW      = DATA_WIDTH / 8;
    localparam int IW      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam int WW      = (TO_LAST > 0) ? $clog2(TO_LAST + 1) : 1;

    localparam logic [IW-1:0] LAST_RST  = IW'(NUM_MASTERS - 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(TO_LAST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    // Index of the most recent owner; while OWN/ERR it is the current owner.
    logic [IW-1:0]          last_q, last_d;
    logic [WW-1:0]          wdog_q, wdog_d;

    // Per-master request slices unpacked into arrays so the owner mux is a
    // plain array read indexed by the owner pointer.
    logic [SW-1:0]         stb_arr  [NUM_MASTERS];
    logic [ADDR_WIDTH-1:0] addr_arr [NUM_MASTERS];
    logic [DATA_WIDTH-1:0] data_arr [NUM_MASTERS];

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
            assign stb_arr[gi]  = m_wb_stb_i[gi*SW +: SW];
            assign addr_arr[gi] = m_wb_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign data_arr[gi] = m_wb_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Round-robin pick: masters above the last owner are searched first,
    // then those at or below it, giving the order last+1, last+2, ... mod N.
    logic          pick_found;
    logic [IW-1:0] pick_idx;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!pick_found && m_wb_cyc_i[i] && (i > int'(last_q))) begin
                pick_found = 1'b1;
                pick_idx   = IW'(i);
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!pick_found && m_wb_cyc_i[i] && (i <= int'(last_q))) begin
                pick_found = 1'b1;
                pick_idx   = IW'(i);
            end
        end
    end

    // The owner's cyc, selected through the one-hot grant.
    logic owner_cyc;
    assign owner_cyc = |(grant_q & m_wb_cyc_i);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        case (state_q)
            IDLE: begin
                wdog_d = '0;
                if (pick_found) begin
                    state_d           = OWN;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    last_d            = pick_idx;
                end
            end
            OWN: begin
                if (!owner_cyc) begin
                    // Owner released the bus; this takes precedence over a
                    // pending timeout because the slave cycle already ended.
                    state_d = IDLE;
                    grant_d = '0;
                    wdog_d  = '0;
                end else if (s_wb_ack_i) begin
                    // An ack on the final watchdog cycle still wins.
                    wdog_d = '0;
                end else if (TIMEOUT_CYCLES > 0) begin
                    if (wdog_q == WDOG_LAST) begin
                        state_d = ERR;
                        wdog_d  = '0;
                    end else begin
                        wdog_d = wdog_q + WW'(1);
                    end
                end
            end
            ERR: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                wdog_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end

    // Slave side: driven only while owning, so everything is 0 in IDLE, ERR
    // and (because the state resets asynchronously) immediately on reset.
    // s_wb_cyc_o follows the owner's cyc combinationally so a release is
    // seen by the slave in the same cycle.
    logic own_active;
    assign own_active = (state_q == OWN);

    assign s_wb_cyc_o  = own_active & owner_cyc;
    assign s_wb_we_o   = own_active & |(grant_q & m_wb_we_i);
    assign s_wb_stb_o  = own_active ? stb_arr[last_q]  : '0;
    assign s_wb_addr_o = own_active ? addr_arr[last_q] : '0;
    assign s_wb_data_o = own_active ? data_arr[last_q] : '0;

    // Acks arriving after the owner dropped cyc are discarded.
    assign m_wb_ack_o  = own_active ? (grant_q & m_wb_cyc_i & {NUM_MASTERS{s_wb_ack_i}}) : '0;
    assign m_wb_err_o  = (state_q == ERR) ? grant_q : '0;
    assign m_wb_data_o = s_wb_data_i;

    assign grant_o = grant_q;
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_rr_arbiter
//
// Directed bench for wb_rr_arbiter (2 masters, 32-bit, watchdog of 8).
// Stimulus pushes expected grant and response events into queues; a monitor
// on the falling clock edge pops and compares them whenever the arbiter
// presents a new grant or an ack/err pulse.
// ---------------------------------------------------------------------------
module tb_wb_rr_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  m_cyc;
    logic [1:0]  m_we;
    logic [3:0]  stb_m  [2];
    logic [31:0] addr_m [2];
    logic [31:0] data_m [2];
    logic [7:0]  m_wb_stb_i;
    logic [63:0] m_wb_addr_i;
    logic [63:0] m_wb_data_i;
    logic [31:0] m_wb_data_o;
    logic [1:0]  m_wb_ack_o;
    logic [1:0]  m_wb_err_o;
    logic        s_wb_cyc_o;
    logic        s_wb_we_o;
    logic [3:0]  s_wb_stb_o;
    logic [31:0] s_wb_addr_o;
    logic [31:0] s_wb_data_o;
    logic [31:0] s_rdata;
    logic        s_ack;
    logic [1:0]  grant_o;
    logic        busy_o;

    assign m_wb_stb_i  = {stb_m[1], stb_m[0]};
    assign m_wb_addr_i = {addr_m[1], addr_m[0]};
    assign m_wb_data_i = {data_m[1], data_m[0]};

    wb_rr_arbiter #(
        .NUM_MASTERS   (2),
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .m_wb_cyc_i (m_cyc),
        .m_wb_we_i  (m_we),
        .m_wb_stb_i (m_wb_stb_i),
        .m_wb_addr_i(m_wb_addr_i),
        .m_wb_data_i(m_wb_data_i),
        .m_wb_data_o(m_wb_data_o),
        .m_wb_ack_o (m_wb_ack_o),
        .m_wb_err_o (m_wb_err_o),
        .s_wb_cyc_o (s_wb_cyc_o),
        .s_wb_we_o  (s_wb_we_o),
        .s_wb_stb_o (s_wb_stb_o),
        .s_wb_addr_o(s_wb_addr_o),
        .s_wb_data_o(s_wb_data_o),
        .s_wb_data_i(s_rdata),
        .s_wb_ack_i (s_ack),
        .grant_o    (grant_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0]  grant;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  stb;
    } gexp_t;

    typedef struct packed {
        logic [1:0]  ack;
        logic [1:0]  err;
        logic        cyc;
        logic [31:0] rdata;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    gexp_t ge;
    rexp_t re;
    logic [1:0] prev_grant = 2'b00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_grant(input int m);
        gexp_t e;
        e.grant = 2'(1 << m);
        e.addr  = addr_m[m];
        e.wdata = data_m[m];
        e.we    = m_we[m];
        e.stb   = stb_m[m];
        gq.push_back(e);
    endtask

    task automatic push_resp(input logic [1:0] ack, input logic [1:0] err,
                             input logic cyc, input logic [31:0] rdata);
        rexp_t e;
        e.ack   = ack;
        e.err   = err;
        e.cyc   = cyc;
        e.rdata = rdata;
        rq.push_back(e);
    endtask

    // Called just after the granting edge: slave acks after lat OWN cycles,
    // then the owner drops cyc; returns in the following IDLE cycle.
    task automatic own_and_ack(input int m, input logic [31:0] rdata,
                               input int lat, input bit reraise);
        repeat (lat) tick();
        s_rdata = rdata;
        s_ack   = 1'b1;
        push_resp(2'(1 << m), 2'b00, 1'b1, rdata);
        tick();
        s_ack    = 1'b0;
        m_cyc[m] = 1'b0;
        tick();
        if (reraise) m_cyc[m] = 1'b1;
    endtask

    // Monitor: compares each new grant and each ack/err pulse with the queues.
    always @(negedge clk_i) begin
        if (grant_o != prev_grant && grant_o != 2'b00) begin
            if (gq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_grant: got %b required none", grant_o);
            end else begin
                ge = gq.pop_front();
                $display("xact grant=%b addr=%h wdata=%h we=%b stb=%h",
                         grant_o, s_wb_addr_o, s_wb_data_o, s_wb_we_o, s_wb_stb_o);
                chk("grant_vec",   64'(grant_o),     64'(ge.grant));
                chk("grant_s_cyc", 64'(s_wb_cyc_o),  64'(1'b1));
                chk("grant_addr",  64'(s_wb_addr_o), 64'(ge.addr));
                chk("grant_wdata", 64'(s_wb_data_o), 64'(ge.wdata));
                chk("grant_we",    64'(s_wb_we_o),   64'(ge.we));
                chk("grant_stb",   64'(s_wb_stb_o),  64'(ge.stb));
            end
        end
        prev_grant <= grant_o;
        if ((m_wb_ack_o | m_wb_err_o) != 2'b00) begin
            if (rq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got ack=%b err=%b required none",
                         m_wb_ack_o, m_wb_err_o);
            end else begin
                re = rq.pop_front();
                $display("xact resp ack=%b err=%b rdata=%h s_cyc=%b",
                         m_wb_ack_o, m_wb_err_o, m_wb_data_o, s_wb_cyc_o);
                chk("resp_ack",   64'(m_wb_ack_o),  64'(re.ack));
                chk("resp_err",   64'(m_wb_err_o),  64'(re.err));
                chk("resp_s_cyc", 64'(s_wb_cyc_o),  64'(re.cyc));
                chk("resp_rdata", 64'(m_wb_data_o), 64'(re.rdata));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_i     = 1'b1;
        m_cyc     = 2'b11;
        m_we      = 2'b00;
        stb_m[0]  = 4'h0;
        stb_m[1]  = 4'h0;
        addr_m[0] = 32'h0;
        addr_m[1] = 32'h0;
        data_m[0] = 32'h0;
        data_m[1] = 32'h0;
        s_rdata   = 32'h0;
        s_ack     = 1'b1;
        tick();
        tick();
        // Reset state with requests and ack present: everything must be 0.
        chk("rst_grant", 64'(grant_o),    64'(2'b00));
        chk("rst_busy",  64'(busy_o),     64'(1'b0));
        chk("rst_s_cyc", 64'(s_wb_cyc_o), 64'(1'b0));
        chk("rst_ack",   64'(m_wb_ack_o), 64'(2'b00));
        chk("rst_err",   64'(m_wb_err_o), 64'(2'b00));
        m_cyc = 2'b00;
        s_ack = 1'b0;
        rst_i = 1'b0;
        tick();

        // 1: single master write, ack on the third OWN cycle, late ack dropped.
        m_we[0]   = 1'b1;
        stb_m[0]  = 4'hF;
        addr_m[0] = 32'h0000_0010;
        data_m[0] = 32'hA5A5_A5A5;
        m_cyc[0]  = 1'b1;
        #1;
        chk("t1_cyc_before_grant", 64'(s_wb_cyc_o), 64'(1'b0));
        push_grant(0);
        tick();
        tick();
        tick();
        s_rdata = 32'hDEAD_BEEF;
        s_ack   = 1'b1;
        push_resp(2'b01, 2'b00, 1'b1, 32'hDEAD_BEEF);
        tick();
        m_cyc[0] = 1'b0;
        #1;
        chk("t1_late_ack_dropped", 64'(m_wb_ack_o), 64'(2'b00));
        chk("t1_s_cyc_follows",    64'(s_wb_cyc_o), 64'(1'b0));
        tick();
        s_ack = 1'b0;
        chk("t1_idle_grant", 64'(grant_o), 64'(2'b00));
        chk("t1_idle_busy",  64'(busy_o),  64'(1'b0));

        // 2: contention right after reset, then strict alternation.
        rst_i = 1'b1;
        tick();
        rst_i     = 1'b0;
        m_we      = 2'b10;
        stb_m[0]  = 4'h3;
        stb_m[1]  = 4'hC;
        addr_m[0] = 32'h0000_0100;
        addr_m[1] = 32'h0000_0200;
        data_m[0] = 32'h1111_1111;
        data_m[1] = 32'h2222_2222;
        m_cyc     = 2'b11;
        push_grant(0);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) m_cyc[0] = 1'b0;
            own_and_ack(i % 2, 32'h5000_0000 + 32'(i), 0, i < 3);
            if (i < 3) begin
                push_grant((i + 1) % 2);
                tick();
            end
        end
        chk("t2_idle_grant", 64'(grant_o), 64'(2'b00));

        // 3: slave never acks -> 8 OWN cycles, then one ERR cycle.
        m_we      = 2'b00;
        stb_m[0]  = 4'hF;
        addr_m[0] = 32'h0000_0040;
        data_m[0] = 32'h0;
        s_rdata   = 32'h0BAD_0BAD;
        m_cyc[0]  = 1'b1;
        push_grant(0);
        tick();
        push_resp(2'b00, 2'b01, 1'b0, 32'h0BAD_0BAD);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t3_s_cyc_held", 64'(s_wb_cyc_o), 64'(1'b1));
            tick();
        end
        m_cyc[0] = 1'b0;
        #1;
        chk("t3_err_s_cyc", 64'(s_wb_cyc_o), 64'(1'b0));
        chk("t3_err_pulse", 64'(m_wb_err_o), 64'(2'b01));
        tick();
        chk("t3_after_err_busy", 64'(busy_o),     64'(1'b0));
        chk("t3_after_err_err",  64'(m_wb_err_o), 64'(2'b00));

        // 4: ack on the last watchdog cycle, twice in one ownership.
        addr_m[0] = 32'h0000_0050;
        m_cyc[0]  = 1'b1;
        push_grant(0);
        tick();
        repeat (7) tick();
        s_rdata = 32'h4444_0001;
        s_ack   = 1'b1;
        push_resp(2'b01, 2'b00, 1'b1, 32'h4444_0001);
        tick();
        s_ack = 1'b0;
        repeat (7) tick();
        s_rdata = 32'h4444_0002;
        s_ack   = 1'b1;
        push_resp(2'b01, 2'b00, 1'b1, 32'h4444_0002);
        tick();
        s_ack    = 1'b0;
        m_cyc[0] = 1'b0;
        tick();

        // 5: m1 toggles while m0 owns; the slave must only see m0.
        addr_m[0] = 32'h0000_0030;
        data_m[0] = 32'h3030_3030;
        m_cyc[0]  = 1'b1;
        push_grant(0);
        tick();
        for (int k = 0; k < 4; k++) begin
            addr_m[1] = 32'hF000_0000 + 32'(k);
            data_m[1] = 32'hEEEE_0000 + 32'(k);
            m_cyc[1]  = k[0];
            #1;
            chk("t5_iso_addr", 64'(s_wb_addr_o), 64'(32'h0000_0030));
            chk("t5_iso_data", 64'(s_wb_data_o), 64'(32'h3030_3030));
            tick();
        end
        m_cyc[1] = 1'b1;
        s_rdata  = 32'h5555_AAAA;
        s_ack    = 1'b1;
        push_resp(2'b01, 2'b00, 1'b1, 32'h5555_AAAA);
        tick();
        s_ack = 1'b0;
        m_cyc = 2'b00;
        tick();

        // 6: async reset while m1 owns; afterwards m0 wins first.
        addr_m[1] = 32'h0000_0060;
        m_cyc[1]  = 1'b1;
        push_grant(1);
        tick();
        tick();
        #2;
        rst_i = 1'b1;
        s_ack = 1'b1;
        #1;
        chk("t6_rst_s_cyc", 64'(s_wb_cyc_o), 64'(1'b0));
        chk("t6_rst_grant", 64'(grant_o),    64'(2'b00));
        chk("t6_rst_busy",  64'(busy_o),     64'(1'b0));
        chk("t6_rst_ack",   64'(m_wb_ack_o), 64'(2'b00));
        chk("t6_rst_err",   64'(m_wb_err_o), 64'(2'b00));
        m_cyc = 2'b11;
        s_ack = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        push_grant(0);
        tick();
        m_cyc[1] = 1'b0;
        own_and_ack(0, 32'h6666_6666, 1, 1'b0);
        tick();
        tick();

        chk("end_grant_queue_empty", 64'(gq.size()), 64'(0));
        chk("end_resp_queue_empty",  64'(rq.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
